// File: rtl/reorder_buffer_commit_pkg.sv
// Shared ROB types and sizing for the retirement stage.
// Entry record layout and tag/count helper types.
package superscalar_pkg;

  localparam int DEPTH  = 8;
  localparam int TAG_W  = 3;
  localparam int REG_W  = 4;
  localparam int DATA_W = 32;

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [TAG_W:0]    cnt_t;
  typedef logic [REG_W-1:0]  reg_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

  typedef struct packed {
    logic  valid;
    logic  done;
    logic  has_dest;
    reg_t  dest;
    data_t data;
  } rob_entry_t;

  function automatic tag_t tag_inc(tag_t t);
    return t + tag_t'(1);
  endfunction

endpackage

// File: rtl/reorder_buffer_commit_if.sv
// Dispatch, CDB, operand-read and ARF-write bundle of the ROB.
// master = core side driving dispatch/CDB, slave = the ROB.
interface reorder_buffer_commit_if;
  import superscalar_pkg::*;

  logic  ALLOC_VALID;
  logic  ALLOC_HAS_DEST;
  reg_t  ALLOC_DEST_REG;
  logic  ALLOC_READY;
  tag_t  ALLOC_TAG;

  logic  CDB_VALID;
  tag_t  CDB_TAG;
  data_t CDB_DATA;

  tag_t  READ_TAG1;
  tag_t  READ_TAG2;
  data_t READ_DATA1;
  data_t READ_DATA2;
  logic  READ_DONE1;
  logic  READ_DONE2;

  logic  WRITE_ENABLE;
  reg_t  WRITE_REG;
  data_t WRITE_DATA;
  tag_t  COMMIT_TAG;
  logic  EMPTY;

  modport master (
    output ALLOC_VALID, ALLOC_HAS_DEST,
    output ALLOC_DEST_REG,
    input  ALLOC_READY, ALLOC_TAG,
    output CDB_VALID, CDB_TAG, CDB_DATA,
    output READ_TAG1, READ_TAG2,
    input  READ_DATA1, READ_DATA2,
    input  READ_DONE1, READ_DONE2,
    input  WRITE_ENABLE, WRITE_REG,
    input  WRITE_DATA, COMMIT_TAG, EMPTY
  );

  modport slave (
    input  ALLOC_VALID, ALLOC_HAS_DEST,
    input  ALLOC_DEST_REG,
    output ALLOC_READY, ALLOC_TAG,
    input  CDB_VALID, CDB_TAG, CDB_DATA,
    input  READ_TAG1, READ_TAG2,
    output READ_DATA1, READ_DATA2,
    output READ_DONE1, READ_DONE2,
    output WRITE_ENABLE, WRITE_REG,
    output WRITE_DATA, COMMIT_TAG, EMPTY
  );

endinterface

// File: rtl/reorder_buffer_commit_rob_entry.sv
// One ROB slot: allocate, capture a CDB result, retire.
// Clear (reset or flush) wins over every other update.
module rob_entry
  import superscalar_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       alloc_i,
  input  logic       has_dest_i,
  input  reg_t       dest_i,
  input  logic       cdb_i,
  input  data_t      cdb_data_i,
  input  logic       retire_i,
  output rob_entry_t entry_o
);

  rob_entry_t ent_q, ent_d;

  always_comb begin
    ent_d = ent_q;
    if (clr_i) begin
      ent_d.valid = 1'b0;
      ent_d.done  = 1'b0;
    end else if (alloc_i) begin
      ent_d.valid    = 1'b1;
      ent_d.done     = 1'b0;
      ent_d.has_dest = has_dest_i;
      ent_d.dest     = dest_i;
    end else if (retire_i) begin
      ent_d.valid = 1'b0;
      ent_d.done  = 1'b0;
    end else if (cdb_i && ent_q.valid
                 && !ent_q.done) begin
      ent_d.data = cdb_data_i;
      ent_d.done = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ent_q <= '0;
    else       ent_q <= ent_d;
  end

  assign entry_o = ent_q;

endmodule

// File: rtl/reorder_buffer_commit.sv
// In-order ROB retirement stage; writer side of the ARF.
// Optional FLUSH port when ROB_FLUSH_EN is defined.
module reorder_buffer_commit
  import superscalar_pkg::*;
(
  input logic CLK,
  input logic RESET,
`ifdef ROB_FLUSH_EN
  input logic FLUSH,
`endif
  reorder_buffer_commit_if.slave rob
);

  logic flush;
`ifdef ROB_FLUSH_EN
  assign flush = FLUSH;
`else
  assign flush = 1'b0;
`endif

  tag_t  head_q, head_d;
  tag_t  tail_q, tail_d;
  cnt_t  count_q, count_d;
  logic  we_q, we_d;
  reg_t  wreg_q, wreg_d;
  data_t wdata_q, wdata_d;
  tag_t  ctag_q, ctag_d;

  rob_entry_t ent [DEPTH];
  rob_entry_t head_ent;
  logic alloc_ready;
  logic alloc_fire;
  logic commit_fire;

  // Readiness from registered count only.
  assign alloc_ready = (count_q < FULL_CNT);
  assign head_ent    = ent[head_q];
  assign alloc_fire  = !flush && rob.ALLOC_VALID
                       && alloc_ready;
  assign commit_fire = !flush && head_ent.valid
                       && head_ent.done;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    rob_entry u_ent (
      .clk_i      (CLK),
      .rst_i      (RESET),
      .clr_i      (flush),
      .alloc_i    (alloc_fire
                   && tail_q == tag_t'(g)),
      .has_dest_i (rob.ALLOC_HAS_DEST),
      .dest_i     (rob.ALLOC_DEST_REG),
      .cdb_i      (rob.CDB_VALID
                   && rob.CDB_TAG == tag_t'(g)),
      .cdb_data_i (rob.CDB_DATA),
      .retire_i   (commit_fire
                   && head_q == tag_t'(g)),
      .entry_o    (ent[g])
    );
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    ctag_d  = ctag_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (alloc_fire) tail_d = tag_inc(tail_q);
      if (commit_fire) begin
        head_d  = tag_inc(head_q);
        we_d    = head_ent.has_dest;
        wreg_d  = head_ent.dest;
        wdata_d = head_ent.data;
        ctag_d  = head_q;
      end
      if (alloc_fire && !commit_fire)
        count_d = count_q + cnt_t'(1);
      else if (!alloc_fire && commit_fire)
        count_d = count_q - cnt_t'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
      ctag_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      ctag_q  <= ctag_d;
    end
  end

  data_t rd1, rd2;
  logic  dn1, dn2;

  // A result on the CDB this cycle bypasses the stored entry.
  always_comb begin
    rd1 = ent[rob.READ_TAG1].data;
    dn1 = ent[rob.READ_TAG1].valid
          && ent[rob.READ_TAG1].done;
    if (rob.CDB_VALID
        && rob.CDB_TAG == rob.READ_TAG1) begin
      rd1 = rob.CDB_DATA;
      dn1 = 1'b1;
    end
  end

  always_comb begin
    rd2 = ent[rob.READ_TAG2].data;
    dn2 = ent[rob.READ_TAG2].valid
          && ent[rob.READ_TAG2].done;
    if (rob.CDB_VALID
        && rob.CDB_TAG == rob.READ_TAG2) begin
      rd2 = rob.CDB_DATA;
      dn2 = 1'b1;
    end
  end

  assign rob.ALLOC_READY  = alloc_ready;
  assign rob.ALLOC_TAG    = tail_q;
  assign rob.READ_DATA1   = rd1;
  assign rob.READ_DATA2   = rd2;
  assign rob.READ_DONE1   = dn1;
  assign rob.READ_DONE2   = dn2;
  assign rob.WRITE_ENABLE = we_q;
  assign rob.WRITE_REG    = wreg_q;
  assign rob.WRITE_DATA   = wdata_q;
  assign rob.COMMIT_TAG   = ctag_q;
  assign rob.EMPTY        = (count_q == '0);

endmodule

// File: tb/tb_reorder_buffer_commit.sv
// Bench for reorder_buffer_commit: ARF-write scoreboard,
// operand-read vector table and multi-cycle corner sequences.
module tb_reorder_buffer_commit;
  import superscalar_pkg::*;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
`ifdef ROB_FLUSH_EN
  logic FLUSH = 1'b0;
`endif

  always #5 CLK = ~CLK;

  reorder_buffer_commit_if bus();

  reorder_buffer_commit dut (
    .CLK   (CLK),
    .RESET (RESET),
`ifdef ROB_FLUSH_EN
    .FLUSH (FLUSH),
`endif
    .rob   (bus)
  );

  typedef struct {
    logic [2:0]  tag;
    logic [3:0]  rg;
    logic [31:0] data;
  } cexp_t;

  typedef struct {
    logic [2:0]  rt1;
    logic [2:0]  rt2;
    logic        cv;
    logic [2:0]  ct;
    logic [31:0] cd;
    logic [31:0] d1;
    logic        dn1;
    logic        ck1;
    logic [31:0] d2;
    logic        dn2;
    logic        ck2;
  } rvec_t;

  int n_vec = 0;
  int n_err = 0;
  cexp_t q[$];
  logic [31:0] pend [8];
  rvec_t tbl [8];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Every ARF write strobe must match the oldest expected commit.
  always @(negedge CLK) begin : mon
    cexp_t e;
    if (!RESET && bus.WRITE_ENABLE === 1'b1) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL wr_unexpected: got reg %0d data %h, want no write",
                 bus.WRITE_REG, bus.WRITE_DATA);
      end else begin
        e = q.pop_front();
        check("wr_reg", 32'(bus.WRITE_REG), 32'(e.rg));
        check("wr_data", bus.WRITE_DATA, e.data);
        check("wr_tag", 32'(bus.COMMIT_TAG), 32'(e.tag));
      end
    end
  end

  task automatic do_reset();
    RESET = 1'b1;
    bus.ALLOC_VALID = 1'b0;
    bus.CDB_VALID = 1'b0;
`ifdef ROB_FLUSH_EN
    FLUSH = 1'b0;
`endif
    q.delete();
    step();
    step();
    RESET = 1'b0;
  endtask

  task automatic alloc(input logic hd,
                       input logic [3:0] rg,
                       input logic [31:0] d,
                       input logic [2:0] t);
    bus.ALLOC_VALID = 1'b1;
    bus.ALLOC_HAS_DEST = hd;
    bus.ALLOC_DEST_REG = rg;
    #1;
    check("alloc_rdy", 32'(bus.ALLOC_READY), 1);
    check("alloc_tag", 32'(bus.ALLOC_TAG), 32'(t));
    pend[t] = d;
    if (hd) q.push_back('{tag: t, rg: rg, data: d});
    @(posedge CLK);
    #1;
    bus.ALLOC_VALID = 1'b0;
  endtask

  task automatic cdb(input logic [2:0] t);
    bus.CDB_VALID = 1'b1;
    bus.CDB_TAG = t;
    bus.CDB_DATA = pend[t];
    step();
    bus.CDB_VALID = 1'b0;
  endtask

  initial begin
    tbl[0] = '{3'd1, 3'd2, 1'b0, 3'd0, 32'h0,
               32'hA1A1_0001, 1'b1, 1'b1,
               32'hB2B2_0002, 1'b1, 1'b1};
    tbl[1] = '{3'd0, 3'd3, 1'b0, 3'd0, 32'h0,
               32'h0, 1'b0, 1'b0,
               32'h0, 1'b0, 1'b0};
    tbl[2] = '{3'd5, 3'd5, 1'b1, 3'd5, 32'h1234,
               32'h1234, 1'b1, 1'b1,
               32'h1234, 1'b1, 1'b1};
    tbl[3] = '{3'd3, 3'd1, 1'b1, 3'd3, 32'hCAFE_F00D,
               32'hCAFE_F00D, 1'b1, 1'b1,
               32'hA1A1_0001, 1'b1, 1'b1};
    tbl[4] = '{3'd6, 3'd7, 1'b0, 3'd0, 32'h0,
               32'h0, 1'b0, 1'b0,
               32'h0, 1'b0, 1'b0};
    tbl[5] = '{3'd1, 3'd0, 1'b1, 3'd1, 32'h55AA_55AA,
               32'h55AA_55AA, 1'b1, 1'b1,
               32'h0, 1'b0, 1'b0};
    tbl[6] = '{3'd3, 3'd2, 1'b0, 3'd3, 32'h1234_5678,
               32'h0, 1'b0, 1'b0,
               32'hB2B2_0002, 1'b1, 1'b1};
    tbl[7] = '{3'd0, 3'd2, 1'b1, 3'd2, 32'h0F0F_0F0F,
               32'h0, 1'b0, 1'b0,
               32'h0F0F_0F0F, 1'b1, 1'b1};

    bus.ALLOC_VALID = 1'b0;
    bus.ALLOC_HAS_DEST = 1'b0;
    bus.ALLOC_DEST_REG = '0;
    bus.CDB_VALID = 1'b0;
    bus.CDB_TAG = '0;
    bus.CDB_DATA = '0;
    bus.READ_TAG1 = '0;
    bus.READ_TAG2 = '0;

    // Reset state, then single alloc/complete/commit.
    do_reset();
    check("rst_we", 32'(bus.WRITE_ENABLE), 0);
    check("rst_wreg", 32'(bus.WRITE_REG), 0);
    check("rst_wdata", bus.WRITE_DATA, 0);
    check("rst_ctag", 32'(bus.COMMIT_TAG), 0);
    check("rst_empty", 32'(bus.EMPTY), 1);
    check("rst_ready", 32'(bus.ALLOC_READY), 1);
    alloc(1'b1, 4'd3, 32'hDEAD_BEEF, 3'd0);
    check("t1_notempty", 32'(bus.EMPTY), 0);
    cdb(3'd0);
    check("t1_we_early", 32'(bus.WRITE_ENABLE), 0);
    step();
    check("t1_we", 32'(bus.WRITE_ENABLE), 1);
    check("t1_wreg", 32'(bus.WRITE_REG), 3);
    check("t1_wdata", bus.WRITE_DATA, 32'hDEAD_BEEF);
    check("t1_ctag", 32'(bus.COMMIT_TAG), 0);
    step();
    check("t1_we_off", 32'(bus.WRITE_ENABLE), 0);
    check("t1_empty", 32'(bus.EMPTY), 1);

    // Out-of-order completion, in-order commit.
    do_reset();
    for (int i = 0; i < 3; i++)
      alloc(1'b1, 4'(i + 8), 32'h2000_0000 + i, 3'(i));
    cdb(3'd2);
    check("t2_hold2", 32'(bus.WRITE_ENABLE), 0);
    cdb(3'd1);
    check("t2_hold1", 32'(bus.WRITE_ENABLE), 0);
    cdb(3'd0);
    check("t2_hold0", 32'(bus.WRITE_ENABLE), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_we", 32'(bus.WRITE_ENABLE), 1);
      check("t2_ctag", 32'(bus.COMMIT_TAG), i);
    end
    step();
    check("t2_we_off", 32'(bus.WRITE_ENABLE), 0);
    check("t2_empty", 32'(bus.EMPTY), 1);

    // Full ROB, ignored 9th alloc, slot freed a cycle late, wrap.
    do_reset();
    for (int i = 0; i < 8; i++)
      alloc(1'b1, 4'(i + 1), 32'h3000_0000 + i, 3'(i));
    check("t3_full", 32'(bus.ALLOC_READY), 0);
    bus.ALLOC_VALID = 1'b1;
    bus.ALLOC_DEST_REG = 4'd9;
    step();
    bus.ALLOC_VALID = 1'b0;
    check("t3_still_full", 32'(bus.ALLOC_READY), 0);
    check("t3_tail", 32'(bus.ALLOC_TAG), 0);
    cdb(3'd0);
    check("t3_rdy_late", 32'(bus.ALLOC_READY), 0);
    step();
    check("t3_rdy_free", 32'(bus.ALLOC_READY), 1);
    alloc(1'b1, 4'hF, 32'h3000_00FF, 3'd0);
    check("t3_refull", 32'(bus.ALLOC_READY), 0);
    for (int i = 1; i < 8; i++) cdb(3'(i));
    cdb(3'd0);
    step();
    step();
    step();
    check("t3_drain", q.size(), 0);
    check("t3_empty", 32'(bus.EMPTY), 1);

    // Commit without a destination register.
    do_reset();
    alloc(1'b1, 4'd7, 32'h4444_0007, 3'd0);
    alloc(1'b0, 4'd6, 32'h4444_0006, 3'd1);
    cdb(3'd0);
    cdb(3'd1);
    check("t4_ctag0", 32'(bus.COMMIT_TAG), 0);
    step();
    check("t4_ctag1", 32'(bus.COMMIT_TAG), 1);
    check("t4_no_we", 32'(bus.WRITE_ENABLE), 0);
    check("t4_empty", 32'(bus.EMPTY), 1);

    // Operand reads: stored values and same-cycle CDB bypass.
    do_reset();
    for (int i = 0; i < 4; i++)
      alloc(1'b1, 4'(i), 32'h0, 3'(i));
    pend[1] = 32'hA1A1_0001;
    pend[2] = 32'hB2B2_0002;
    cdb(3'd1);
    cdb(3'd2);
    for (int i = 0; i < 8; i++) begin
      bus.READ_TAG1 = tbl[i].rt1;
      bus.READ_TAG2 = tbl[i].rt2;
      bus.CDB_VALID = tbl[i].cv;
      bus.CDB_TAG = tbl[i].ct;
      bus.CDB_DATA = tbl[i].cd;
      #1;
      check($sformatf("rd_done1[%0d]", i),
            32'(bus.READ_DONE1), 32'(tbl[i].dn1));
      check($sformatf("rd_done2[%0d]", i),
            32'(bus.READ_DONE2), 32'(tbl[i].dn2));
      if (tbl[i].ck1)
        check($sformatf("rd_data1[%0d]", i),
              bus.READ_DATA1, tbl[i].d1);
      if (tbl[i].ck2)
        check($sformatf("rd_data2[%0d]", i),
              bus.READ_DATA2, tbl[i].d2);
      bus.CDB_VALID = 1'b0;
      step();
    end
    check("t5_no_commit", 32'(bus.EMPTY), 0);

    // Reset in mid-operation drops a pending commit.
    do_reset();
    alloc(1'b1, 4'd5, 32'h7777_0005, 3'd1 - 3'd1);
    alloc(1'b1, 4'd2, 32'h7777_0002, 3'd1);
    cdb(3'd0);
    step();
    check("t7_ctag_pre", 32'(bus.COMMIT_TAG), 0);
    cdb(3'd1);
    RESET = 1'b1;
    q.delete();
    step();
    check("t7_we", 32'(bus.WRITE_ENABLE), 0);
    check("t7_ctag", 32'(bus.COMMIT_TAG), 0);
    check("t7_empty", 32'(bus.EMPTY), 1);
    RESET = 1'b0;
    step();
    check("t7_we_after", 32'(bus.WRITE_ENABLE), 0);

`ifdef ROB_FLUSH_EN
    // Flush beats a completing head on the same edge.
    do_reset();
    for (int i = 0; i < 4; i++)
      alloc(1'b1, 4'(i + 1), 32'h6000_0000 + i, 3'(i));
    bus.CDB_VALID = 1'b1;
    bus.CDB_TAG = 3'd0;
    bus.CDB_DATA = 32'h6000_0000;
    FLUSH = 1'b1;
    q.delete();
    step();
    bus.CDB_VALID = 1'b0;
    FLUSH = 1'b0;
    check("t6_we", 32'(bus.WRITE_ENABLE), 0);
    check("t6_empty", 32'(bus.EMPTY), 1);
    check("t6_tag", 32'(bus.ALLOC_TAG), 0);
    check("t6_ready", 32'(bus.ALLOC_READY), 1);
    step();
    check("t6_we_after", 32'(bus.WRITE_ENABLE), 0);
    check("t6_empty2", 32'(bus.EMPTY), 1);
`endif

    step();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
